// File: rtl/toggle_seq.sv
// toggle_seq: sequences an external bank of toggle cells through timed patterns.
// Handshake: start in IDLE, stop in CLR/RUN, one-cycle done on len-limited completion.
module toggle_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4,
  parameter int unsigned LENW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [LENW-1:0]  len,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_vec,
  output logic             clr_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] M_COUNT = 2'b00;
  localparam logic [1:0] M_BLINK = 2'b01;
  localparam logic [1:0] M_WALK  = 2'b10;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   presc;
  logic [LENW-1:0] tick_cnt;
  logic [LENW-1:0] len_r;
  logic [1:0]      mode_r;
  logic            tick_c;
  logic            last_c;

  // A tick is the last prescaler cycle in RUN; a coinciding stop suppresses it.
  assign tick_c = (state == S_RUN) && (presc == PW'(DIV - 1)) && !stop;
  // The tick being issued is the final one of a len-limited run.
  assign last_c = (len_r != '0) && ((tick_cnt + LENW'(1)) == len_r);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Run configuration latch, prescaler and saturating tick counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r   <= 2'b00;
      len_r    <= '0;
      presc    <= '0;
      tick_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        mode_r <= mode;
        len_r  <= len;
      end
      if (state == S_CLR) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (state == S_RUN) begin
        presc <= (presc == PW'(DIV - 1)) ? '0 : presc + PW'(1);
        if (tick_c && (tick_cnt != '1)) tick_cnt <= tick_cnt + LENW'(1);
      end
    end
  end

  // Next-state logic; stop has priority over run completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CLR;
      S_CLR:  state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)                 state_nxt = S_IDLE;
        else if (tick_c && last_c) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; t_vec is formed from q_fb only in tick cycles
  always_comb begin
    logic carry;
    t_vec   = '0;
    carry   = 1'b1;
    busy    = (state != S_IDLE);
    clr_out = (state == S_CLR);
    done    = (state == S_DONE);
    if (tick_c) begin
      case (mode_r)
        M_COUNT: begin
          for (int i = 0; i < WIDTH; i++) begin
            t_vec[i] = carry;
            carry    = carry & q_fb[i];
          end
        end
        M_BLINK: t_vec = '1;
        M_WALK: begin
          if (q_fb == '0) t_vec = WIDTH'(1);
          else            t_vec = q_fb | {q_fb[WIDTH-2:0], q_fb[WIDTH-1]};
        end
        default: t_vec = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_seq.sv
// tb_toggle_seq: scoreboard bench for toggle_seq with a behavioural toggle bank.
module tb_toggle_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned LENW  = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [LENW-1:0]  len;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] t_vec;
  logic             clr_out;
  logic             busy;
  logic             done;

  typedef struct {
    int         cyc;
    logic [3:0] t;
    logic [3:0] q;
  } tick_t;

  tick_t tq[$];
  int    dq[$];
  tick_t mon_e;
  int    cyc;
  int    n_chk;
  int    n_pass;
  int    c0;

  toggle_seq #(.WIDTH(WIDTH), .DIV(DIV), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .len(len),
    .q_fb(q_fb), .t_vec(t_vec), .clr_out(clr_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toggle bank: T flip-flops with async active-high clear from clr_out
  always @(posedge clk or posedge clr_out) begin
    if (clr_out) q_fb <= '0;
    else         q_fb <= q_fb ^ t_vec;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Expected tick cycle, toggle vector and bank contents before each tick
  task automatic push_ticks(input int base, input logic [1:0] m, input int n);
    logic [3:0] walk_q [8];
    logic [3:0] walk_t [8];
    tick_t e;
    int b;
    walk_q = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    walk_t = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3, 4'h6, 4'hC};
    for (int k = 1; k <= n; k++) begin
      e.cyc = base + 1 + DIV * k;
      b = (k - 1) % 16;
      case (m)
        2'b00: begin e.q = 4'(b); e.t = 4'(b ^ (b + 1)); end
        2'b01: begin e.q = ((k - 1) % 2 == 1) ? 4'hF : 4'h0; e.t = 4'hF; end
        default: begin e.q = walk_q[(k - 1) % 8]; e.t = walk_t[(k - 1) % 8]; end
      endcase
      if (m != 2'b11) tq.push_back(e);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input int l, input int npush, output int base);
    step();
    start = 1'b1; mode = m; len = 8'(l); base = cyc;
    push_ticks(base, m, npush);
    if (l != 0) dq.push_back(base + 2 + DIV * l);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    step();
    start = 1'b0; mode = 2'($urandom); len = 8'($urandom);
    @(negedge clk);
    chk("clr_out", 32'(clr_out), 1);
    chk("busy_clr", 32'(busy), 1);
    chk("bank_clr", 32'(q_fb), 0);
    step();
    @(negedge clk);
    chk("clr_drop", 32'(clr_out), 0);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      chk("busy_run", 32'(busy), 1);
    end
    chk("done_seen", 32'(seen), 1);
    step();
    @(negedge clk);
    chk("busy_after", 32'(busy), 0);
  endtask

  task automatic queues_empty();
    chk("tick_q_left", 32'(tq.size()), 0);
    chk("done_q_left", 32'(dq.size()), 0);
  endtask

  // Scoreboard monitor: every nonzero t_vec and every done pulse must be expected
  always @(negedge clk) begin
    if (rst) begin
      if (t_vec != '0) begin
        if (tq.size() == 0) chk("tick_unexpected", 32'(t_vec), 0);
        else begin
          mon_e = tq.pop_front();
          chk("tick_cyc", cyc, mon_e.cyc);
          chk("tick_t", 32'(t_vec), 32'(mon_e.t));
          chk("tick_q", 32'(q_fb), 32'(mon_e.q));
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cyc", cyc, dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; len = '0;
    #1 rst = 1'b0;

    // Held in reset: inputs toggling must not move any output
    for (int i = 0; i < 16; i++) begin
      step();
      start = 1'($urandom); stop = 1'($urandom);
      mode = 2'($urandom); len = 8'($urandom);
      @(negedge clk);
      chk("rst_hold", 32'({t_vec, clr_out, busy, done}), 0);
    end
    step();
    start = 1'b0; stop = 1'b0; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_after_rst", 32'({t_vec, clr_out, busy, done}), 0);
    end

    // Binary count, 5 ticks
    start_run(2'b00, 5, 5, c0);
    wait_done(40);
    chk("count5_bank", 32'(q_fb), 32'h5);
    queues_empty();

    // Binary count, 16 ticks: wraps back to zero
    start_run(2'b00, 16, 16, c0);
    wait_done(80);
    chk("count16_bank", 32'(q_fb), 32'h0);
    queues_empty();

    // Walk, 6 ticks
    start_run(2'b10, 6, 6, c0);
    wait_done(40);
    chk("walk_bank", 32'(q_fb), 32'h2);
    queues_empty();

    // Hold: ticks counted but no toggles
    start_run(2'b11, 3, 0, c0);
    wait_done(30);
    chk("hold_bank", 32'(q_fb), 32'h0);
    queues_empty();

    // Blink free-run, start ignored in RUN, stop in the 4th tick cycle
    start_run(2'b01, 0, 3, c0);
    wait_until(c0 + 6);
    start = 1'b1; mode = 2'b00; len = 8'd1;
    step();
    start = 1'b0;
    wait_until(c0 + 1 + DIV * 4);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_t_vec", 32'(t_vec), 0);
    chk("stop_busy", 32'(busy), 1);
    step();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_idle", 32'(busy), 0);
    chk("blink_bank", 32'(q_fb), 32'hF);
    for (int i = 0; i < 6; i++) step();
    queues_empty();

    // Async reset mid-run after 2 ticks, then a fresh run
    start_run(2'b00, 0, 2, c0);
    wait_until(c0 + 10);
    rst = 1'b0;
    #1;
    chk("arst_outs", 32'({t_vec, clr_out, busy, done}), 0);
    chk("arst_bank", 32'(q_fb), 32'h2);
    queues_empty();
    step();
    rst = 1'b1;
    start_run(2'b00, 3, 3, c0);
    wait_done(30);
    chk("restart_bank", 32'(q_fb), 32'h3);
    queues_empty();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
